// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared constants and types for the Pong input front end
package pong_pkg;

  // Default number of active-low player buttons
  localparam int N_BTN_DEF = 2;

  // Default width of each initial speed field (x and y)
  localparam int SPEED_W_DEF = 2;

  // Pixel coordinate width shared with vga_sync
  localparam int PIX_W_DEF = 10;

  // Consecutive stable clocks needed before a new button level is accepted
  localparam int DEBOUNCE_CYCLES_DEF = 4;

  // Initial ball speed selection as seen by game_control
  typedef struct packed {
    logic [SPEED_W_DEF-1:0] x;
    logic [SPEED_W_DEF-1:0] y;
  } init_speed_t;

  // Counter width for a debounce window, kept at least one bit wide
  function automatic int debounce_cnt_w(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// rtl/debounce_chan.sv - one button channel: 2-FF synchroniser followed by a debouncer
module debounce_chan
  import pong_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic raw_i,
  output logic stable_o
);

  localparam int CNT_W = debounce_cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_meta;
  logic             sync_q;
  logic [CNT_W-1:0] cnt;

  // Two-flop synchroniser for the asynchronous pin level
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_meta <= 1'b0;
      sync_q    <= 1'b0;
    end else begin
      sync_meta <= raw_i;
      sync_q    <= sync_meta;
    end
  end

  // Accept a new level only after it differs from the stable one for a full unbroken window
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt      <= '0;
      stable_o <= 1'b0;
    end else if (sync_q == stable_o) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      stable_o <= sync_q;
      cnt      <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pong_input_frontend.sv
// rtl/pong_input_frontend.sv - button/start/speed conditioning aligned to the VGA frame tick
module pong_input_frontend
  import pong_pkg::*;
#(
  parameter int N_BTN           = N_BTN_DEF,
  parameter int SPEED_W         = SPEED_W_DEF,
  parameter int PIX_W           = PIX_W_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               start_n_i,
  input  logic [N_BTN-1:0]   btn_n_i,
  input  logic [SPEED_W-1:0] speed_x_n_i,
  input  logic [SPEED_W-1:0] speed_y_n_i,
  input  logic [PIX_W-1:0]   pix_x_i,
  input  logic [PIX_W-1:0]   pix_y_i,
  output logic               frame_tick_o,
  output logic [N_BTN-1:0]   btn_level_o,
  output logic [N_BTN-1:0]   btn_press_o,
  output logic               start_pulse_o,
  output logic [SPEED_W-1:0] speed_x_o,
  output logic [SPEED_W-1:0] speed_y_o
);

  // Channel N_BTN is the start button; the rest are player buttons
  logic [N_BTN:0]     raw_act;
  logic [N_BTN:0]     stable;

  logic [SPEED_W-1:0] spx_meta;
  logic [SPEED_W-1:0] spx_sync;
  logic [SPEED_W-1:0] spy_meta;
  logic [SPEED_W-1:0] spy_sync;

  logic               at_org;
  logic               at_org_q;
  logic               tick_edge;
  logic               start_seen;
  logic               start_rise;

  // Pins are active low; everything downstream is active high
  assign raw_act = {~start_n_i, ~btn_n_i};

  genvar g;
  generate
    for (g = 0; g <= N_BTN; g++) begin : g_chan
      debounce_chan #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_chan (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .raw_i    (raw_act[g]),
        .stable_o (stable[g])
      );
    end
  endgenerate

  // Speed switches are static settings, so only synchronise them
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      spx_meta <= '0;
      spx_sync <= '0;
      spy_meta <= '0;
      spy_sync <= '0;
    end else begin
      spx_meta <= ~speed_x_n_i;
      spx_sync <= spx_meta;
      spy_meta <= ~speed_y_n_i;
      spy_sync <= spy_meta;
    end
  end

  // Only the first cycle of the origin counts, however long vga_sync sits there
  assign at_org    = (pix_x_i == '0) && (pix_y_i == '0);
  assign tick_edge = at_org & ~at_org_q;
  assign start_rise = stable[N_BTN] & ~start_seen;

  // Remember last cycle's origin state for the rising-edge detect
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      at_org_q     <= 1'b0;
      frame_tick_o <= 1'b0;
    end else begin
      at_org_q     <= at_org;
      frame_tick_o <= tick_edge;
    end
  end

  // Sample debounced levels once per frame and derive press/start pulses on that same edge
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      btn_level_o   <= '0;
      btn_press_o   <= '0;
      start_pulse_o <= 1'b0;
      start_seen    <= 1'b0;
      speed_x_o     <= '0;
      speed_y_o     <= '0;
    end else if (tick_edge) begin
      btn_level_o   <= stable[N_BTN-1:0];
      btn_press_o   <= stable[N_BTN-1:0] & ~btn_level_o;
      start_pulse_o <= start_rise;
      start_seen    <= stable[N_BTN];
      if (start_rise) begin
        speed_x_o <= spx_sync;
        speed_y_o <= spy_sync;
      end
    end else begin
      btn_press_o   <= '0;
      start_pulse_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pong_input_frontend.sv
// tb/tb_pong_input_frontend.sv - directed and randomized bench for pong_input_frontend
module tb_pong_input_frontend;

  localparam int N_BTN   = 2;
  localparam int SPEED_W = 2;
  localparam int PIX_W   = 10;
  localparam int DB      = 4;

  logic               clk;
  logic               rst_n;
  logic               start_n;
  logic [N_BTN-1:0]   btn_n;
  logic [SPEED_W-1:0] speed_x_n;
  logic [SPEED_W-1:0] speed_y_n;
  logic [PIX_W-1:0]   pix_x;
  logic [PIX_W-1:0]   pix_y;
  logic               frame_tick;
  logic [N_BTN-1:0]   btn_level;
  logic [N_BTN-1:0]   btn_press;
  logic               start_pulse;
  logic [SPEED_W-1:0] speed_x;
  logic [SPEED_W-1:0] speed_y;

  int tests = 0;
  int fails = 0;

  pong_input_frontend #(
    .N_BTN           (N_BTN),
    .SPEED_W         (SPEED_W),
    .PIX_W           (PIX_W),
    .DEBOUNCE_CYCLES (DB)
  ) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .start_n_i     (start_n),
    .btn_n_i       (btn_n),
    .speed_x_n_i   (speed_x_n),
    .speed_y_n_i   (speed_y_n),
    .pix_x_i       (pix_x),
    .pix_y_i       (pix_y),
    .frame_tick_o  (frame_tick),
    .btn_level_o   (btn_level),
    .btn_press_o   (btn_press),
    .start_pulse_o (start_pulse),
    .speed_x_o     (speed_x),
    .speed_y_o     (speed_y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: pin history per cycle, levels judged by run length
  logic [N_BTN:0]     m_hist[$];
  logic [SPEED_W-1:0] mx_hist[$];
  logic [SPEED_W-1:0] my_hist[$];
  logic [N_BTN:0]     m_stable;
  logic               m_org_q;
  logic               m_seen;
  logic               exp_tick;
  logic [N_BTN-1:0]   exp_lvl;
  logic [N_BTN-1:0]   exp_press;
  logic               exp_spulse;
  logic [SPEED_W-1:0] exp_sx;
  logic [SPEED_W-1:0] exp_sy;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_hist.delete();
    mx_hist.delete();
    my_hist.delete();
    repeat (DB + 2) m_hist.push_front('0);
    repeat (3) mx_hist.push_front('0);
    repeat (3) my_hist.push_front('0);
    m_stable   = '0;
    m_org_q    = 1'b0;
    m_seen     = 1'b0;
    exp_tick   = 1'b0;
    exp_lvl    = '0;
    exp_press  = '0;
    exp_spulse = 1'b0;
    exp_sx     = '0;
    exp_sy     = '0;
  endtask

  // Predict what the coming clock edge does, given the inputs held across it
  task automatic model_edge();
    logic org;
    logic [N_BTN:0] h;
    bit all_diff;
    if (!rst_n) begin
      model_reset();
      return;
    end
    m_hist.push_front({~start_n, ~btn_n});
    void'(m_hist.pop_back());
    mx_hist.push_front(~speed_x_n);
    void'(mx_hist.pop_back());
    my_hist.push_front(~speed_y_n);
    void'(my_hist.pop_back());
    org        = (pix_x == 0) && (pix_y == 0);
    exp_tick   = org && !m_org_q;
    m_org_q    = org;
    exp_press  = '0;
    exp_spulse = 1'b0;
    if (exp_tick) begin
      exp_press = m_stable[N_BTN-1:0] & ~exp_lvl;
      exp_lvl   = m_stable[N_BTN-1:0];
      if (m_stable[N_BTN] && !m_seen) begin
        exp_spulse = 1'b1;
        exp_sx     = mx_hist[2];
        exp_sy     = my_hist[2];
      end
      m_seen = m_stable[N_BTN];
    end
    // A level is accepted once the synchronised pin disagreed with it for DB straight cycles
    for (int c = 0; c <= N_BTN; c++) begin
      all_diff = 1'b1;
      for (int j = 2; j < DB + 2; j++) begin
        h = m_hist[j];
        if (h[c] == m_stable[c]) all_diff = 1'b0;
      end
      if (all_diff) m_stable[c] = ~m_stable[c];
    end
  endtask

  task automatic cyc();
    model_edge();
    @(posedge clk);
    #1;
    chk("tick", frame_tick, exp_tick);
    chk("level", btn_level, exp_lvl);
    chk("press", btn_press, exp_press);
    chk("start_pulse", start_pulse, exp_spulse);
    chk("speed_x", speed_x, exp_sx);
    chk("speed_y", speed_y, exp_sy);
  endtask

  task automatic set_org(input bit o);
    if (o) begin
      pix_x = '0;
      pix_y = '0;
    end else begin
      pix_x = PIX_W'($urandom_range(1, 639));
      pix_y = PIX_W'($urandom_range(0, 479));
    end
  endtask

  // Drop reset between edges and confirm outputs clear without a clock
  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_tick", frame_tick, 0);
    chk("arst_level", btn_level, 0);
    chk("arst_press", btn_press, 0);
    chk("arst_start", start_pulse, 0);
    chk("arst_speed_x", speed_x, 0);
    chk("arst_speed_y", speed_y, 0);
  endtask

  initial begin
    int ticks;
    int b;
    rst_n     = 1'b0;
    start_n   = 1'b1;
    btn_n     = '1;
    speed_x_n = '1;
    speed_y_n = '1;
    set_org(1'b0);
    model_reset();
    repeat (3) cyc();
    rst_n = 1'b1;

    // Reset state, then a single-cycle origin at cycle 10
    repeat (9) cyc();
    chk("rst_level", btn_level, 0);
    chk("rst_tick", frame_tick, 0);
    set_org(1'b1);
    cyc();
    chk("first_tick", frame_tick, 1);
    chk("first_tick_level", btn_level, 0);
    chk("first_tick_start", start_pulse, 0);
    set_org(1'b0);
    cyc();
    chk("first_tick_gone", frame_tick, 0);

    // Origin held for five cycles gives one tick
    ticks = 0;
    set_org(1'b1);
    repeat (5) begin
      cyc();
      ticks += int'(frame_tick);
    end
    set_org(1'b0);
    repeat (2) begin
      cyc();
      ticks += int'(frame_tick);
    end
    chk("hold_origin_ticks", ticks, 1);

    // Button 0 held long enough, then a tick
    btn_n[0] = 1'b0;
    repeat (8) cyc();
    set_org(1'b1);
    cyc();
    chk("b0_level", btn_level, 2'b01);
    chk("b0_press", btn_press, 2'b01);
    set_org(1'b0);
    cyc();
    chk("b0_press_once", btn_press, 2'b00);
    repeat (3) cyc();
    set_org(1'b1);
    cyc();
    chk("b0_level_hold", btn_level, 2'b01);
    chk("b0_no_repress", btn_press, 2'b00);
    set_org(1'b0);

    // Button 1 bounces, then a short hold: not accepted by the next tick
    foreach (btn_n[i]) begin end
    btn_n[1] = 1'b0; cyc();
    btn_n[1] = 1'b1; cyc();
    btn_n[1] = 1'b0; cyc();
    btn_n[1] = 1'b1; cyc();
    btn_n[1] = 1'b0;
    repeat (3) cyc();
    set_org(1'b1);
    cyc();
    chk("bounce_level1", btn_level[1], 0);
    set_org(1'b0);

    // Start with speed switches, then a later tick with start still held
    speed_x_n = 2'b10;
    speed_y_n = 2'b01;
    start_n   = 1'b0;
    repeat (10) cyc();
    set_org(1'b1);
    cyc();
    chk("start_pulse", start_pulse, 1);
    chk("start_speed_x", speed_x, 2'b01);
    chk("start_speed_y", speed_y, 2'b10);
    set_org(1'b0);
    cyc();
    chk("start_pulse_once", start_pulse, 0);
    repeat (5) cyc();
    set_org(1'b1);
    cyc();
    chk("start_no_repulse", start_pulse, 0);
    chk("start_speed_kept", speed_x, 2'b01);
    set_org(1'b0);
    cyc();

    // Both buttons held, reset in the middle, re-report after debounce
    set_org(1'b1);
    cyc();
    chk("both_level", btn_level, 2'b11);
    set_org(1'b0);
    cyc();
    async_reset();
    repeat (2) cyc();
    rst_n = 1'b1;
    set_org(1'b1);
    cyc();
    chk("post_rst_level", btn_level, 0);
    chk("post_rst_press", btn_press, 0);
    set_org(1'b0);
    repeat (8) cyc();
    set_org(1'b1);
    cyc();
    chk("post_rst_repress", btn_press, 2'b11);
    chk("post_rst_relevel", btn_level, 2'b11);
    set_org(1'b0);
    cyc();

    // Randomized phase against the model
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        b = int'($urandom_range(0, N_BTN - 1));
        btn_n[b] = ~btn_n[b];
      end
      if ($urandom_range(0, 11) == 0) start_n = ~start_n;
      if ($urandom_range(0, 19) == 0) begin
        speed_x_n = SPEED_W'($urandom);
        speed_y_n = SPEED_W'($urandom);
      end
      set_org($urandom_range(0, 9) == 0);
      if (i == 300) begin
        async_reset();
        cyc();
        rst_n = 1'b1;
      end
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
